// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_bus_pkg : bus index map, request kinds, sequencer state codes    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package cpu_bus_pkg;

  localparam int IDX_R0     = 0;
  localparam int IDX_R15    = 15;
  localparam int IDX_HI     = 16;
  localparam int IDX_LO     = 17;
  localparam int IDX_ZH     = 18;
  localparam int IDX_ZL     = 19;
  localparam int IDX_PC     = 20;
  localparam int IDX_MDR    = 21;
  localparam int IDX_INPORT = 22;
  localparam int IDX_CSE    = 23;

  localparam logic [1:0] KIND_MOVE = 2'd0;
  localparam logic [1:0] KIND_ALU  = 2'd1;
  localparam logic [1:0] KIND_WIDE = 2'd2;
  localparam logic [1:0] KIND_BAD  = 2'd3;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_MV = 3'd1;
  localparam logic [STATE_W-1:0] S_A  = 3'd2;
  localparam logic [STATE_W-1:0] S_B  = 3'd3;
  localparam logic [STATE_W-1:0] S_WL = 3'd4;
  localparam logic [STATE_W-1:0] S_WH = 3'd5;

  function automatic logic src_ok(input int idx);
    return (idx >= IDX_R0) && (idx <= IDX_CSE);
  endfunction

  // Z halves, InPort and the sign-extend constant are read-only bus sources.
  function automatic logic dst_ok(input int idx);
    return ((idx >= IDX_R0) && (idx <= IDX_LO)) || (idx == IDX_PC) || (idx == IDX_MDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_onehot_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_onehot_dec : index + enable to one-hot vector (zero if disabled) |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module bus_onehot_dec #(
  parameter int IDX_W = 5,
  parameter int VEC_W = 32
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [VEC_W-1:0] vec
);

  // Out-of-range indices match no bit, so the vector stays zero.
  for (genvar i = 0; i < VEC_W; i++) begin : g_bit
    assign vec[i] = en && (int'(idx) == i);
  end

endmodule
`default_nettype wire

// File: rtl/bus_microseq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_microseq : expands bus transfer requests into per-cycle selects  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module bus_microseq
  import cpu_bus_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int VEC_W = 32,
  parameter int OP_W  = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [IDX_W-1:0] req_src_a,
  input  logic [IDX_W-1:0] req_src_b,
  input  logic [IDX_W-1:0] req_dst,
  input  logic [OP_W-1:0]  req_aluop,
  output logic [VEC_W-1:0] Rout,
  output logic [VEC_W-1:0] Rin,
  output logic             Yin,
  output logic             Zin,
  output logic [OP_W-1:0]  alu_op,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_nextState;
  logic [1:0]         r_kind;
  logic [IDX_W-1:0]   r_srcA, r_srcB, r_dst;
  logic [OP_W-1:0]    r_aluop;

  logic               w_finalStep, w_accept, w_illegal;
  logic [1:0]         w_kind;
  logic [IDX_W-1:0]   w_srcA, w_srcB, w_dst;
  logic [OP_W-1:0]    w_aluop;
  logic [IDX_W-1:0]   w_routIdx, w_rinIdx;
  logic               w_routEn, w_rinEn, w_yin, w_zin, w_done;
  logic [VEC_W-1:0]   w_routVec, w_rinVec;

  assign w_finalStep = (r_state == S_MV) || (r_state == S_WH) ||
                       ((r_state == S_WL) && (r_kind != KIND_WIDE));
  assign req_ready   = (r_state == IDLE) || w_finalStep;
  assign w_accept    = req_valid && req_ready;

  assign w_illegal = (req_kind == KIND_BAD) ||
                     !src_ok(int'(req_src_a)) ||
                     ((req_kind != KIND_MOVE) && !src_ok(int'(req_src_b))) ||
                     ((req_kind != KIND_WIDE) && !dst_ok(int'(req_dst)));

  // Outputs are registered from the next step, so a fresh accept must see the live fields.
  assign w_kind  = w_accept ? req_kind  : r_kind;
  assign w_srcA  = w_accept ? req_src_a : r_srcA;
  assign w_srcB  = w_accept ? req_src_b : r_srcB;
  assign w_dst   = w_accept ? req_dst   : r_dst;
  assign w_aluop = w_accept ? req_aluop : r_aluop;

  always_comb begin
    w_nextState = IDLE;
    if (w_accept) begin
      if (w_illegal)
        w_nextState = IDLE;
      else if (req_kind == KIND_MOVE)
        w_nextState = S_MV;
      else
        w_nextState = S_A;
    end else begin
      case (r_state)
        S_A:     w_nextState = S_B;
        S_B:     w_nextState = S_WL;
        S_WL:    w_nextState = (r_kind == KIND_WIDE) ? S_WH : IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    w_routEn  = 1'b0;
    w_routIdx = '0;
    w_rinEn   = 1'b0;
    w_rinIdx  = '0;
    w_yin     = 1'b0;
    w_zin     = 1'b0;
    w_done    = 1'b0;
    case (w_nextState)
      S_MV: begin
        w_routEn  = 1'b1;
        w_routIdx = w_srcA;
        w_rinEn   = 1'b1;
        w_rinIdx  = w_dst;
        w_done    = 1'b1;
      end
      S_A: begin
        w_routEn  = 1'b1;
        w_routIdx = w_srcA;
        w_yin     = 1'b1;
      end
      S_B: begin
        w_routEn  = 1'b1;
        w_routIdx = w_srcB;
        w_zin     = 1'b1;
      end
      S_WL: begin
        w_routEn  = 1'b1;
        w_routIdx = IDX_W'(IDX_ZL);
        w_rinEn   = 1'b1;
        w_rinIdx  = (w_kind == KIND_WIDE) ? IDX_W'(IDX_LO) : w_dst;
        w_done    = (w_kind != KIND_WIDE);
      end
      S_WH: begin
        w_routEn  = 1'b1;
        w_routIdx = IDX_W'(IDX_ZH);
        w_rinEn   = 1'b1;
        w_rinIdx  = IDX_W'(IDX_HI);
        w_done    = 1'b1;
      end
      default: begin
        w_routEn = 1'b0;
      end
    endcase
  end

  bus_onehot_dec #(.IDX_W(IDX_W), .VEC_W(VEC_W)) u_routDec (
    .idx (w_routIdx),
    .en  (w_routEn),
    .vec (w_routVec)
  );

  bus_onehot_dec #(.IDX_W(IDX_W), .VEC_W(VEC_W)) u_rinDec (
    .idx (w_rinIdx),
    .en  (w_rinEn),
    .vec (w_rinVec)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
      r_kind  <= KIND_MOVE;
      r_srcA  <= '0;
      r_srcB  <= '0;
      r_dst   <= '0;
      r_aluop <= '0;
      Rout    <= '0;
      Rin     <= '0;
      Yin     <= 1'b0;
      Zin     <= 1'b0;
      alu_op  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_kind  <= req_kind;
        r_srcA  <= req_src_a;
        r_srcB  <= req_src_b;
        r_dst   <= req_dst;
        r_aluop <= req_aluop;
      end
      Rout <= w_routVec;
      Rin  <= w_rinVec;
      Yin  <= w_yin;
      Zin  <= w_zin;
      busy <= (w_nextState != IDLE);
      done <= w_done;
      err  <= w_accept && w_illegal;
      if (w_nextState == S_B)
        alu_op <= w_aluop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_microseq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_microseq : scoreboard bench for the bus micro-step sequencer  |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_bus_microseq;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [4:0]  req_src_a, req_src_b, req_dst, req_aluop;
  logic [31:0] Rout, Rin;
  logic        Yin, Zin, busy, done, err;
  logic [4:0]  alu_op;

  bus_microseq #(.IDX_W(5), .VEC_W(32), .OP_W(5)) dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_src_a (req_src_a),
    .req_src_b (req_src_b),
    .req_dst   (req_dst),
    .req_aluop (req_aluop),
    .Rout      (Rout),
    .Rin       (Rin),
    .Yin       (Yin),
    .Zin       (Zin),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] rout;
    logic [31:0] rin;
    logic        yin;
    logic        zin;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0] kind;
    int a, b, d, op, gap;
  } req_t;

  exp_t       q[$];
  req_t       tbl[$];
  logic [4:0] mdlOp;
  int         nVec = 0;
  int         nErr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rout, input logic [31:0] rin,
                              input logic yin, input logic zin, input logic [4:0] op,
                              input logic bsy, input logic dn, input logic er);
    exp_t e;
    e.rout = rout; e.rin = rin; e.yin = yin; e.zin = zin;
    e.op = op; e.busy = bsy; e.done = dn; e.err = er;
    return e;
  endfunction

  task automatic push_req(input req_t r);
    bit dstGood = (r.d <= 17) || (r.d == 20) || (r.d == 21);
    bit bad = (r.kind == 2'd3) || (r.a > 23) || ((r.kind != 2'd0) && (r.b > 23)) ||
              ((r.kind != 2'd2) && !dstGood);
    logic [31:0] one = 32'd1;
    if (bad) begin
      q.push_back(mk(0, 0, 0, 0, mdlOp, 0, 0, 1));
    end else if (r.kind == 2'd0) begin
      q.push_back(mk(one << r.a, one << r.d, 0, 0, mdlOp, 1, 1, 0));
    end else begin
      q.push_back(mk(one << r.a, 0, 1, 0, mdlOp, 1, 0, 0));
      mdlOp = 5'(r.op);
      q.push_back(mk(one << r.b, 0, 0, 1, mdlOp, 1, 0, 0));
      if (r.kind == 2'd1) begin
        q.push_back(mk(one << 19, one << r.d, 0, 0, mdlOp, 1, 1, 0));
      end else begin
        q.push_back(mk(one << 19, one << 17, 0, 0, mdlOp, 1, 0, 0));
        q.push_back(mk(one << 18, one << 16, 0, 0, mdlOp, 1, 1, 0));
      end
    end
  endtask

  // One clock: compare this cycle's outputs against the next scoreboard entry.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (q.size() > 0) e = q.pop_front();
    else              e = mk(0, 0, 0, 0, mdlOp, 0, 0, 0);
    chk("rout",  Rout, e.rout);
    chk("rin",   Rin,  e.rin);
    chk("yin",   32'(Yin),    32'(e.yin));
    chk("zin",   32'(Zin),    32'(e.zin));
    chk("aluop", 32'(alu_op), 32'(e.op));
    chk("busy",  32'(busy),   32'(e.busy));
    chk("done",  32'(done),   32'(e.done));
    chk("err",   32'(err),    32'(e.err));
    chk("ready", 32'(req_ready), 32'(q.size() == 0));
    chk("onehot", 32'($onehot0(Rout) && $onehot0(Rin)), 32'd1);
    chk("rinmask", Rin & 32'hFFCC_0000, 32'd0);
  endtask

  task automatic drive(input req_t r);
    int budget = 0;
    req_kind  = r.kind;
    req_src_a = 5'(r.a);
    req_src_b = 5'(r.b);
    req_dst   = 5'(r.d);
    req_aluop = 5'(r.op);
    req_valid = 1'b1;
    while (q.size() != 0 && budget < 8) begin
      tick();
      budget++;
    end
    push_req(r);
    tick();
    req_valid = 1'b0;
    req_kind  = 2'($urandom);
    req_src_a = 5'($urandom);
    req_src_b = 5'($urandom);
    req_dst   = 5'($urandom);
    req_aluop = 5'($urandom);
  endtask

  always @(negedge clock) begin
    assert ($onehot0(Rout) && $onehot0(Rin))
      else $error("onehot0 violated Rout=%h Rin=%h", Rout, Rin);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_t r;
    clear = 1'b1; req_valid = 1'b0; req_kind = '0;
    req_src_a = '0; req_src_b = '0; req_dst = '0; req_aluop = '0;
    mdlOp = '0;

    // kind, src_a, src_b, dst, op, idle gap before
    tbl.push_back('{2'd0,  3,  0,  7, 0, 1});
    tbl.push_back('{2'd1,  1,  2,  4, 3, 1});
    tbl.push_back('{2'd2,  5,  6,  0, 9, 1});
    tbl.push_back('{2'd0,  8,  0,  9, 0, 1});
    tbl.push_back('{2'd1, 10, 11, 12, 7, 0});
    tbl.push_back('{2'd2, 23, 20, 31, 4, 0});
    tbl.push_back('{2'd0, 21,  0, 20, 0, 0});
    tbl.push_back('{2'd0,  0,  0, 19, 0, 1});
    tbl.push_back('{2'd1, 25,  1,  2, 1, 0});
    tbl.push_back('{2'd3,  1,  2,  3, 5, 0});
    tbl.push_back('{2'd2,  2, 24,  0, 5, 1});
    tbl.push_back('{2'd1,  4,  5, 18, 6, 0});
    tbl.push_back('{2'd1,  7,  8, 17, 2, 0});
    tbl.push_back('{2'd0, 16,  0,  0, 0, 2});

    repeat (2) @(negedge clock);
    chk("rst_rout", Rout, 32'd0);
    chk("rst_rin",  Rin,  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op",   32'(alu_op), 32'd0);
    chk("rst_done", 32'(done | err | Yin | Zin), 32'd0);
    clear = 1'b0;

    foreach (tbl[i]) begin
      repeat (tbl[i].gap) tick();
      drive(tbl[i]);
    end
    while (q.size() != 0) tick();
    tick();

    // Asynchronous clear in the middle of an ALU operand-B step.
    r = '{2'd1, 1, 2, 4, 3, 0};
    drive(r);
    tick();
    #2 clear = 1'b1;
    #1;
    chk("clr_rout", Rout, 32'd0);
    chk("clr_zin",  32'(Zin), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_op",   32'(alu_op), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    q.delete();
    mdlOp = '0;
    @(posedge clock);
    #1 clear = 1'b0;
    tick();
    r = '{2'd0, 3, 0, 7, 0, 0};
    drive(r);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
